// File: rtl/scope_sel_ctrl.sv
// Scope selector sequencer: collects load / button / auto-dwell requests into
// a pending target and commits them to sig_sel/mod_sel only on a sample_tick,
// so the scope never switches waveform in the middle of a sample.
module scope_sel_ctrl #(
  parameter int NUM_SIG     = 4,
  parameter int NUM_MOD     = 4,
  parameter int DWELL_TICKS = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       btn_next_sig,
  input  logic       btn_next_mod,
  input  logic       load,
  input  logic [3:0] sw_sig,
  input  logic [3:0] sw_mod,
  input  logic       auto_en,
  output logic [3:0] sig_sel,
  output logic [3:0] mod_sel,
  output logic       sel_update,
  output logic       busy
);

  localparam int              CNT_W    = $clog2(DWELL_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_TICKS - 1);
  localparam logic [3:0]      SIG_LAST = 4'(NUM_SIG - 1);
  localparam logic [3:0]      MOD_LAST = 4'(NUM_MOD - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Out-of-range switch values select entry 0 rather than an invalid source.
  function automatic logic [3:0] clamp_sel(input logic [3:0] v, input logic [3:0] last);
    return (v <= last) ? v : 4'd0;
  endfunction

  // Step to the next selection, wrapping after the last valid one.
  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] last);
    return (v >= last) ? 4'd0 : v + 4'd1;
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       tgt_sig, tgt_mod, tgt_sig_nxt, tgt_mod_nxt;
  logic [3:0]       sig_sel_nxt, mod_sel_nxt;
  logic             sel_update_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic             btn_q_sig, btn_q_mod;

  logic             edge_sig, edge_mod, auto_req, manual_req, any_req;
  logic [3:0]       base_sig, base_mod, req_sig, req_mod;

  // Request arbitration, dwell timer and IDLE/PENDING next-state logic.
  always_comb begin
    edge_sig   = btn_next_sig & ~btn_q_sig;
    edge_mod   = btn_next_mod & ~btn_q_mod;
    auto_req   = auto_en & sample_tick & (dwell_cnt == CNT_MAX);

    // While a change is pending, new requests build on the target so that
    // repeated presses before a tick accumulate instead of being lost.
    base_sig   = (state == PENDING) ? tgt_sig : sig_sel;
    base_mod   = (state == PENDING) ? tgt_mod : mod_sel;

    req_sig    = base_sig;
    req_mod    = base_mod;
    manual_req = 1'b0;
    any_req    = 1'b0;

    // Only the highest-priority request class is taken in a cycle.
    if (load) begin
      req_sig    = clamp_sel(sw_sig, SIG_LAST);
      req_mod    = clamp_sel(sw_mod, MOD_LAST);
      manual_req = 1'b1;
      any_req    = 1'b1;
    end else if (edge_sig || edge_mod) begin
      if (edge_sig) req_sig = wrap_inc(base_sig, SIG_LAST);
      if (edge_mod) req_mod = wrap_inc(base_mod, MOD_LAST);
      manual_req = 1'b1;
      any_req    = 1'b1;
    end else if (auto_req) begin
      req_mod = wrap_inc(base_mod, MOD_LAST);
      if (base_mod == MOD_LAST) req_sig = wrap_inc(base_sig, SIG_LAST);
      any_req = 1'b1;
    end

    // A manual change restarts the dwell so auto-cycling does not step
    // immediately after the user picked something.
    dwell_cnt_nxt = dwell_cnt;
    if (!auto_en || manual_req) begin
      dwell_cnt_nxt = '0;
    end else if (sample_tick) begin
      dwell_cnt_nxt = (dwell_cnt == CNT_MAX) ? '0 : dwell_cnt + CNT_W'(1);
    end

    state_nxt      = state;
    tgt_sig_nxt    = tgt_sig;
    tgt_mod_nxt    = tgt_mod;
    sig_sel_nxt    = sig_sel;
    mod_sel_nxt    = mod_sel;
    sel_update_nxt = 1'b0;

    case (state)
      IDLE: begin
        // A tick in the request cycle is deliberately not used for commit.
        if (any_req) begin
          state_nxt   = PENDING;
          tgt_sig_nxt = req_sig;
          tgt_mod_nxt = req_mod;
        end
      end
      PENDING: begin
        tgt_sig_nxt = req_sig;
        tgt_mod_nxt = req_mod;
        if (sample_tick) begin
          sig_sel_nxt    = req_sig;
          mod_sel_nxt    = req_mod;
          sel_update_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, target, output and edge-detect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tgt_sig    <= 4'd0;
      tgt_mod    <= 4'd0;
      sig_sel    <= 4'd0;
      mod_sel    <= 4'd0;
      sel_update <= 1'b0;
      dwell_cnt  <= '0;
      btn_q_sig  <= 1'b0;
      btn_q_mod  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tgt_sig    <= tgt_sig_nxt;
      tgt_mod    <= tgt_mod_nxt;
      sig_sel    <= sig_sel_nxt;
      mod_sel    <= mod_sel_nxt;
      sel_update <= sel_update_nxt;
      dwell_cnt  <= dwell_cnt_nxt;
      btn_q_sig  <= btn_next_sig;
      btn_q_mod  <= btn_next_mod;
    end
  end

  assign busy = (state == PENDING);

endmodule

// File: tb/tb_scope_sel_ctrl.sv
// Bench for scope_sel_ctrl: fixed vector table, auto-cycle sequences and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_scope_sel_ctrl;

  localparam int NSIG  = 4;
  localparam int NMOD  = 4;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       reset, sample_tick, btn_next_sig, btn_next_mod, load, auto_en;
  logic [3:0] sw_sig, sw_mod;
  logic [3:0] sig_sel, mod_sel;
  logic       sel_update, busy;

  int checks   = 0;
  int failures = 0;

  scope_sel_ctrl #(.NUM_SIG(NSIG), .NUM_MOD(NMOD), .DWELL_TICKS(DWELL)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .btn_next_sig(btn_next_sig), .btn_next_mod(btn_next_mod),
    .load(load), .sw_sig(sw_sig), .sw_mod(sw_mod), .auto_en(auto_en),
    .sig_sel(sig_sel), .mod_sel(mod_sel), .sel_update(sel_update), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: committed selection, optional pending target, dwell.
  int m_sig, m_mod, m_tsig, m_tmod, m_cnt, m_upd;
  bit m_pend, m_bs, m_bm;

  task automatic model_step();
    int  bsig, bmod, nsig, nmod;
    bit  req, manual, es, em;
    if (reset) begin
      m_sig = 0; m_mod = 0; m_tsig = 0; m_tmod = 0; m_cnt = 0; m_upd = 0;
      m_pend = 0; m_bs = 0; m_bm = 0;
      return;
    end
    es   = btn_next_sig && !m_bs;
    em   = btn_next_mod && !m_bm;
    bsig = m_pend ? m_tsig : m_sig;
    bmod = m_pend ? m_tmod : m_mod;
    nsig = bsig; nmod = bmod; req = 0; manual = 0;
    if (load) begin
      nsig = (int'(sw_sig) < NSIG) ? int'(sw_sig) : 0;
      nmod = (int'(sw_mod) < NMOD) ? int'(sw_mod) : 0;
      req = 1; manual = 1;
    end else if (es || em) begin
      if (es) nsig = (bsig + 1) % NSIG;
      if (em) nmod = (bmod + 1) % NMOD;
      req = 1; manual = 1;
    end else if (auto_en && sample_tick && m_cnt == DWELL - 1) begin
      nmod = (bmod + 1) % NMOD;
      if (bmod == NMOD - 1) nsig = (bsig + 1) % NSIG;
      req = 1;
    end
    if (!auto_en || manual) m_cnt = 0;
    else if (sample_tick)   m_cnt = (m_cnt + 1) % DWELL;
    m_upd = 0;
    if (m_pend && sample_tick) begin
      m_sig = nsig; m_mod = nmod; m_upd = 1; m_pend = 0;
    end else if (m_pend || req) begin
      m_pend = 1; m_tsig = nsig; m_tmod = nmod;
    end
    m_bs = btn_next_sig;
    m_bm = btn_next_mod;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; sample_tick = 0; btn_next_sig = 0; btn_next_mod = 0;
    load = 0; sw_sig = 0; sw_mod = 0;
  endtask

  typedef struct {
    logic       rst, tick, bs, bm, ld;
    logic [3:0] ssw, msw;
    logic [3:0] e_sig, e_mod;
    logic       e_upd, e_busy;
  } vec_t;
  vec_t vt[$];

  task automatic v(input logic r, t, bs_i, bm_i, ld, input logic [3:0] ss, ms,
                   input logic [3:0] es, em, input logic eu, eb);
    vec_t x;
    x.rst = r; x.tick = t; x.bs = bs_i; x.bm = bm_i; x.ld = ld;
    x.ssw = ss; x.msw = ms; x.e_sig = es; x.e_mod = em; x.e_upd = eu; x.e_busy = eb;
    vt.push_back(x);
  endtask

  typedef struct { int k; int s; int m; } cmt_t;
  cmt_t cq[$];

  // Auto-cycle run with a tick every 5 cycles; records (tick index, sel) per commit.
  task automatic run_auto(input int ncyc, input int press_at);
    int ticks = 0;
    cmt_t c;
    cq.delete();
    idle_inputs();
    auto_en = 0;
    reset = 1; cyc(); reset = 0;
    auto_en = 1;
    for (int i = 0; i < ncyc; i++) begin
      sample_tick  = (i % 5 == 4);
      if (sample_tick) ticks++;
      btn_next_mod = (i == press_at);
      cyc();
      if (sel_update === 1'b1) begin
        c.k = ticks; c.s = int'(sig_sel); c.m = int'(mod_sel);
        cq.push_back(c);
      end
    end
    idle_inputs();
  endtask

  task automatic chk_commits(input string tag, input cmt_t exp[$]);
    int n;
    chk($sformatf("%s_count", tag), cq.size(), exp.size());
    n = (cq.size() < exp.size()) ? cq.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_tick%0d", tag, i), cq[i].k, exp[i].k);
      chk($sformatf("%s_sig%0d", tag, i),  cq[i].s, exp[i].s);
      chk($sformatf("%s_mod%0d", tag, i),  cq[i].m, exp[i].m);
    end
  endtask

  initial begin
    cmt_t ex[$];
    cmt_t e;
    idle_inputs();
    auto_en = 0;

    //  rst tick bs bm ld ssw  msw  | sig mod upd busy
    v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 1);   // btn at cycle 3 with a tick
    v(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    v(0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0);   // tick at cycle 6 commits
    v(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    v(0, 0, 0, 1, 1, 9, 2,   1, 0, 0, 1);   // load clamps sig, drops button
    v(0, 1, 0, 1, 0, 0, 0,   0, 2, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0);
    v(0, 0, 0, 0, 1, 1, 0,   0, 2, 0, 1);   // target (1,0)
    v(0, 1, 0, 1, 0, 0, 0,   1, 1, 1, 0);   // mod edge merged on tick
    v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    v(0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1);   // IDLE request on tick waits
    v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1);
    v(0, 1, 0, 0, 0, 0, 0,   2, 1, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0);
    v(0, 0, 0, 0, 1, 3, 0,   2, 1, 0, 1);   // go to sig=3
    v(0, 1, 0, 0, 0, 0, 0,   3, 0, 1, 0);
    v(0, 0, 1, 0, 0, 0, 0,   3, 0, 0, 1);   // two presses accumulate
    v(0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1);
    v(0, 0, 1, 0, 0, 0, 0,   3, 0, 0, 1);
    v(0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    v(0, 0, 0, 0, 1, 2, 3,   1, 0, 0, 1);   // load then reset before tick
    v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    v(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0);   // button held through reset
    v(0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 1);
    v(0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; sample_tick = vt[i].tick;
      btn_next_sig = vt[i].bs; btn_next_mod = vt[i].bm; load = vt[i].ld;
      sw_sig = vt[i].ssw; sw_mod = vt[i].msw;
      cyc();
      chk($sformatf("vec%0d_sig", i),  sig_sel,    vt[i].e_sig);
      chk($sformatf("vec%0d_mod", i),  mod_sel,    vt[i].e_mod);
      chk($sformatf("vec%0d_upd", i),  sel_update, vt[i].e_upd);
      chk($sformatf("vec%0d_busy", i), busy,       vt[i].e_busy);
    end
    idle_inputs();

    // Free-running auto-cycle: commits one tick after each 4th-tick request.
    run_auto(86, -1);
    ex.delete();
    e.k = 5;  e.s = 0; e.m = 1; ex.push_back(e);
    e.k = 9;  e.s = 0; e.m = 2; ex.push_back(e);
    e.k = 13; e.s = 0; e.m = 3; ex.push_back(e);
    e.k = 17; e.s = 1; e.m = 0; ex.push_back(e);
    chk_commits("auto", ex);

    // Button between tick 2 and tick 3 restarts the dwell count.
    run_auto(41, 12);
    ex.delete();
    e.k = 3; e.s = 0; e.m = 1; ex.push_back(e);
    e.k = 7; e.s = 0; e.m = 2; ex.push_back(e);
    chk_commits("restart", ex);

    // Randomized run against the model.
    auto_en = 1;
    reset = 1; cyc(); reset = 0;
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      sample_tick  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) btn_next_sig = ~btn_next_sig;
      if ($urandom_range(0, 2) == 0) btn_next_mod = ~btn_next_mod;
      load         = ($urandom_range(0, 19) == 0);
      sw_sig       = 4'($urandom_range(0, 15));
      sw_mod       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      cyc();
      chk($sformatf("rnd%0d_sig", i),  sig_sel,    m_sig);
      chk($sformatf("rnd%0d_mod", i),  mod_sel,    m_mod);
      chk($sformatf("rnd%0d_upd", i),  sel_update, m_upd);
      chk($sformatf("rnd%0d_busy", i), busy,       32'(m_pend));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_sel_ctrl.md
# scope_sel_ctrl

Controller that sequences the scope selector's `sig_sel` / `mod_sel` configuration on the DE1-SoC signal-generator design. It accepts the following requests:
- direct loads from switches;
- step requests from push-buttons;
- an optional auto-cycle dwell timer.

Every selection change is deferred to a DDS `sample_tick` boundary, so the scope outputs never switch mid-sample. It sits between the board I/O and the scope selector and drives that block's select inputs.

## Interface
- `NUM_SIG`, 4: number of valid signal selections (0=sin, 1=cos, 2=saw, 3=squ).
- `NUM_MOD`, 4: number of valid modulation selections (0=ask, 1=fsk, 2=bpsk, 3=lfsr).
- `DWELL_TICKS`, 48000: sample ticks per auto-cycle step; must be ≥2.

- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `sample_tick` in 1: one-cycle strobe at the DDS sample rate.
- `btn_next_sig` in 1: level input; each rising edge requests sig +1.
- `btn_next_mod` in 1: level input; each rising edge requests mod +1.
- `load` in 1: one-cycle pulse; requests `sig_sel<=sw_sig`, `mod_sel<=sw_mod`.
- `sw_sig` in 4: switch value for signal select.
- `sw_mod` in 4: switch value for modulation select.
- `auto_en` in 1: enables auto-cycling.
- `sig_sel` out 4: registered signal select.
- `mod_sel` out 4: registered modulation select.
- `sel_update` out 1: one-cycle pulse; the selects changed this cycle.
- `busy` out 1: a change is pending (state PENDING).

## Operation
- **State machine:** states IDLE and PENDING.
  - Holding registers: `tgt_sig` and `tgt_mod` (the pending target values).
  - A `btn_q` register per button for rising-edge detection.
- **Reset values:**
  - `sig_sel=0`, `mod_sel=0`, `tgt_*=0`.
  - `sel_update=0`, `busy=0`, state IDLE.
  - `dwell_cnt=0`, `btn_q=0`.
  - A button held through reset therefore yields one step in the first cycle after reset.
- **Request sources and priority:** `load` > button edges > auto step. Only one class is accepted per cycle; lower-priority requests in that cycle are dropped.
  - **load:**
    - `tgt_sig = sw_sig` if `sw_sig < NUM_SIG`, else 0.
    - `tgt_mod = sw_mod` if `sw_mod < NUM_MOD`, else 0.
  - **buttons:** `tgt_sig = (base_sig+1) mod NUM_SIG` and/or `tgt_mod = (base_mod+1) mod NUM_MOD`. Both buttons may step in the same cycle.
  - **auto:** `tgt_mod = (base_mod+1) mod NUM_MOD`. If `base_mod == NUM_MOD-1`, `tgt_sig` also steps, with wrap.
  - **base values:** `base_*` = current `sig_sel`/`mod_sel` in IDLE, or `tgt_*` in PENDING. Requests made while PENDING therefore accumulate.
- **State transitions:**
  - IDLE + request → PENDING. A `sample_tick` in the same cycle does not commit.
  - PENDING + `sample_tick` → commit: `sig_sel<=tgt_sig`, `mod_sel<=tgt_mod`, `sel_update<=1`, → IDLE. A request in that same cycle is merged into the target before the commit.
  - PENDING without `sample_tick` → stay PENDING.
- **Commit rules:**
  - `sel_update` pulses on every commit, even when the committed value equals the old value.
  - `sel_update` is 0 in all other cycles.
- **Dwell counter:**
  - Clears to 0 whenever `auto_en=0`, and on any accepted manual request (load or button).
  - Otherwise it increments on `sample_tick`.
  - On a `sample_tick` with `dwell_cnt == DWELL_TICKS-1`, it wraps to 0 and raises an auto request in that cycle.
- **Reset mid-operation:** any pending target is discarded and outputs return to their reset values on the next edge.

## Timing
- Request in cycle n:
  - `busy=1` from n+1.
  - The commit happens at the end of the first cycle m ≥ n+1 with `sample_tick=1`.
  - New `sig_sel`/`mod_sel` and `sel_update=1` are visible in cycle m+1 only.
- Minimum latency from request to new select is 2 cycles (tick in n+1).
- `busy` falls in the same cycle that `sel_update` rises.
- `btn` rising edge is detected combinationally from `btn & ~btn_q` in the cycle the level first reads 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset and single step:** reset, then `btn_next_sig` rises at cycle 3 with `sample_tick` at cycles 3 and 6 → `busy` high over cycles 4–6; `sig_sel=1` and `sel_update=1` at cycle 7; `mod_sel=0`.
- **Wrap and accumulation:**
  - Start from `sig_sel=3`.
  - Press `btn_next_sig` twice before a tick.
  - Required: one commit with `sig_sel=1` and exactly one `sel_update` pulse.
- **Load clamp and priority:**
  - Stimulus: `sw_sig=4'h9`, `sw_mod=2`, `load` in the same cycle as a `btn_next_mod` edge.
  - Required: commit `sig_sel=0`, `mod_sel=2`, with the button dropped.
- **Auto-cycle (`DWELL_TICKS=4`, tick every 5 cycles, `auto_en=1`):**
  - Required sequence: (0,1), (0,2), (0,3), (1,0), one commit per 4 ticks. Each commit lands on the tick after its auto request.
  - Pressing a button mid-dwell restarts the 4-tick count.
- **Tick coincidence:**
  - A request in IDLE on a tick cycle is not applied until the next tick.
  - A `btn_next_mod` edge while PENDING on a tick cycle is merged: target (1,0) plus mod step → commit (1,1).
- **Reset while PENDING:** `load sw=(2,3)`, then `reset` before any tick → `sig_sel=0`, `mod_sel=0`, `busy=0`; no `sel_update` on the following tick.
